// File: rtl/udp_tx_framer.sv
// udp_tx_framer
//   Takes one request at a time from the SDR packet sender and prepends the
//   8-byte UDP header (source port, destination port, length, zero checksum).
//   It then streams the sender's payload to the IP transmit layer at one
//   byte per cycle. Backpressure from the IP layer (ip_tx_ready) stalls the
//   sender through udp_tx_active. Oversize requests are granted and drained:
//   the sender's bytes are consumed and discarded without any IP request.
//
// Optional build macro: UDP_TX_STATS_EN
//   Defined   : packet_count (wrapping) and drop_count (saturating) are live.
//   Undefined : both outputs are tied to zero and no counter logic exists.
//
// Ports
//   tx_clock, reset      clock (rising edge), synchronous active-high reset
//   udp_tx_request       sender has a packet pending (held until it idles)
//   udp_tx_length        payload byte count L
//   udp_tx_data          current payload byte from the sender
//   port_ID, dest_port   source-port offset, UDP destination port
//   udp_tx_enable        one-cycle grant pulse to the sender
//   udp_tx_active        sender byte is consumed this cycle
//   ip_tx_request/length request to the IP layer, datagram length L+8
//   ip_tx_enable         grant from the IP layer
//   ip_tx_ready          IP layer accepts a byte this cycle
//   ip_tx_data/valid/last byte stream to the IP layer
//   busy                 framer is not idle
//   packet_count         datagrams sent
//   drop_count           oversize requests discarded
module udp_tx_framer #(
  parameter logic [15:0] MAX_PAYLOAD   = 16'd1472,
  parameter logic [15:0] SRC_PORT_BASE = 16'd1024
) (
  input  logic        tx_clock,
  input  logic        reset,
  input  logic        udp_tx_request,
  input  logic [15:0] udp_tx_length,
  input  logic [7:0]  udp_tx_data,
  input  logic [7:0]  port_ID,
  input  logic [15:0] dest_port,
  output logic        udp_tx_enable,
  output logic        udp_tx_active,
  output logic        ip_tx_request,
  output logic [15:0] ip_tx_length,
  input  logic        ip_tx_enable,
  input  logic        ip_tx_ready,
  output logic [7:0]  ip_tx_data,
  output logic        ip_tx_valid,
  output logic        ip_tx_last,
  output logic        busy,
  output logic [31:0] packet_count,
  output logic [15:0] drop_count
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_IP_REQ    = 3'd1;
  localparam logic [2:0] ST_GRANT     = 3'd2;
  localparam logic [2:0] ST_HEADER    = 3'd3;
  localparam logic [2:0] ST_PAYLOAD   = 3'd4;
  localparam logic [2:0] ST_DRAIN_GNT = 3'd5;
  localparam logic [2:0] ST_DRAIN     = 3'd6;
  localparam logic [2:0] ST_DONE      = 3'd7;

  logic [2:0]  state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  pid_q, pid_d;
  logic [15:0] dport_q, dport_d;
  // Shared byte index: header byte number in HEADER, payload/drain count
  // in PAYLOAD and DRAIN. Always compared against the latched length.
  logic [15:0] cnt_q, cnt_d;

  logic [15:0] src_port;
  logic [15:0] dgram_len;
  logic [7:0]  hdr_byte;

  assign src_port  = SRC_PORT_BASE + {8'h00, pid_q};
  assign dgram_len = len_q + 16'd8;
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    hdr_byte = 8'h00;
    case (cnt_q[2:0])
      3'd0:    hdr_byte = src_port[15:8];
      3'd1:    hdr_byte = src_port[7:0];
      3'd2:    hdr_byte = dport_q[15:8];
      3'd3:    hdr_byte = dport_q[7:0];
      3'd4:    hdr_byte = dgram_len[15:8];
      3'd5:    hdr_byte = dgram_len[7:0];
      default: hdr_byte = 8'h00;  // checksum not computed
    endcase
  end

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    pid_d         = pid_q;
    dport_d       = dport_q;
    cnt_d         = cnt_q;
    udp_tx_enable = 1'b0;
    udp_tx_active = 1'b0;
    ip_tx_request = 1'b0;
    ip_tx_length  = 16'h0000;
    ip_tx_data    = 8'h00;
    ip_tx_valid   = 1'b0;
    ip_tx_last    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (udp_tx_request) begin
          len_d   = udp_tx_length;
          pid_d   = port_ID;
          dport_d = dest_port;
          cnt_d   = 16'd0;
          state_d = (udp_tx_length > MAX_PAYLOAD) ? ST_DRAIN_GNT : ST_IP_REQ;
        end
      end

      ST_IP_REQ: begin
        ip_tx_request = 1'b1;
        ip_tx_length  = dgram_len;
        // A sender that withdraws before being granted is simply forgotten.
        if (!udp_tx_request) begin
          state_d = ST_IDLE;
        end else if (ip_tx_enable) begin
          state_d = ST_GRANT;
        end
      end

      ST_GRANT: begin
        udp_tx_enable = 1'b1;
        ip_tx_length  = dgram_len;
        cnt_d         = 16'd0;
        state_d       = ST_HEADER;
      end

      ST_HEADER: begin
        ip_tx_valid  = 1'b1;
        ip_tx_data   = hdr_byte;
        ip_tx_length = dgram_len;
        ip_tx_last   = (cnt_q[2:0] == 3'd7) && (len_q == 16'd0);
        if (ip_tx_ready) begin
          if (cnt_q[2:0] == 3'd7) begin
            cnt_d   = 16'd0;
            state_d = (len_q == 16'd0) ? ST_DONE : ST_PAYLOAD;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end

      ST_PAYLOAD: begin
        // len_q >= 1 here, so len_q - 1 cannot underflow.
        ip_tx_valid   = 1'b1;
        ip_tx_data    = udp_tx_data;
        ip_tx_length  = dgram_len;
        udp_tx_active = ip_tx_ready;
        ip_tx_last    = (cnt_q == len_q - 16'd1);
        if (ip_tx_ready) begin
          if (cnt_q == len_q - 16'd1) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end

      ST_DRAIN_GNT: begin
        udp_tx_enable = 1'b1;
        cnt_d         = 16'd0;
        state_d       = ST_DRAIN;
      end

      ST_DRAIN: begin
        // Consume one sender byte per cycle regardless of the IP layer.
        udp_tx_active = 1'b1;
        if (cnt_q == len_q - 16'd1) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_DONE: begin
        // Require the request to drop before re-arming so a request held
        // high is never serviced twice.
        if (!udp_tx_request) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge tx_clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      len_q   <= 16'd0;
      pid_q   <= 8'd0;
      dport_q <= 16'd0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      pid_q   <= pid_d;
      dport_q <= dport_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef UDP_TX_STATS_EN
  logic        pkt_done;
  logic        pkt_drop;
  logic [31:0] pkt_cnt_q;
  logic [15:0] drop_cnt_q;

  assign pkt_done = ((state_q == ST_HEADER) || (state_q == ST_PAYLOAD)) &&
                    (state_d == ST_DONE);
  assign pkt_drop = (state_q == ST_DRAIN) && (state_d == ST_DONE);

  always_ff @(posedge tx_clock) begin
    if (reset) begin
      pkt_cnt_q  <= 32'd0;
      drop_cnt_q <= 16'd0;
    end else begin
      if (pkt_done) begin
        pkt_cnt_q <= pkt_cnt_q + 32'd1;
      end
      if (pkt_drop && (drop_cnt_q != 16'hFFFF)) begin
        drop_cnt_q <= drop_cnt_q + 16'd1;
      end
    end
  end

  assign packet_count = pkt_cnt_q;
  assign drop_count   = drop_cnt_q;
`else
  assign packet_count = 32'd0;
  assign drop_count   = 16'd0;
`endif

endmodule

// File: doc/udp_tx_framer.md
Name: udp_tx_framer

Overview:
- Sits directly downstream of the SDR packet sender (CC, mic, wideband, DDC and discovery/response traffic).
- Arbitrates one sender request at a time and prepends the 8-byte UDP header.
- Streams the sender's payload bytes to the IP transmit layer, pacing the sender through `udp_tx_enable` and `udp_tx_active`.
- Has one clock and one byte per cycle. Backpressure from the IP layer stalls the sender.

Parameters:
- MAX_PAYLOAD, 16'd1472: largest UDP payload in bytes that is forwarded. Larger requests are consumed and discarded.
- SRC_PORT_BASE, 16'd1024: source port = SRC_PORT_BASE + `port_ID`.

Ports:
- `tx_clock`  in  1  system transmit clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `udp_tx_request`  in  1  sender has a packet pending; held until the sender returns to idle
- `udp_tx_length`  in  16  payload byte count, including the sender's sequence/header bytes
- `udp_tx_data`  in  8  current payload byte from the sender
- `port_ID`  in  8  source-port offset
- `dest_port`  in  16  UDP destination port, PC side
- `udp_tx_enable`  out  1  grant to the sender
- `udp_tx_active`  out  1  the byte on `udp_tx_data` is consumed this cycle
- `ip_tx_request`  out  1  request to the IP layer
- `ip_tx_length`  out  16  UDP datagram length = `udp_tx_length` + 8
- `ip_tx_enable`  in  1  grant from the IP layer
- `ip_tx_ready`  in  1  IP layer accepts a byte this cycle
- `ip_tx_data`  out  8  byte to the IP layer
- `ip_tx_valid`  out  1  `ip_tx_data` is valid; a transfer occurs when valid and ready are both high
- `ip_tx_last`  out  1  marks the final byte of the datagram
- `busy`  out  1  high in every state except IDLE
- `packet_count`  out  32  datagrams sent (optional feature)
- `drop_count`  out  16  oversize requests discarded (optional feature)

Behaviour:
- **Reset values:** all outputs are 0 and state = IDLE. Reset in any state aborts the packet on the next edge; no `ip_tx_last` is issued.
- **IDLE:**
  - On `udp_tx_request`, latch length L, `port_ID`, and `dest_port`.
  - If L > MAX_PAYLOAD, go to DRAIN; otherwise go to IP_REQ.
- **IP_REQ:**
  - Assert `ip_tx_request`; `ip_tx_length` = L + 8, 16-bit.
  - On `ip_tx_enable`, go to GRANT.
- **GRANT:**
  - Assert `udp_tx_enable` for exactly 1 cycle, then go to HEADER.
  - The sender presents its first byte on the following cycle.
- **HEADER:** emit 8 bytes MSB first, advancing only on valid&ready:
  - source port = SRC_PORT_BASE + `port_ID`
  - `dest_port`
  - L + 8
  - checksum 16'h0000
  - When the 8th byte transfers: if L == 0, go to DONE with `ip_tx_last` on that byte; otherwise go to PAYLOAD.
- **PAYLOAD:**
  - `udp_tx_active` = `ip_tx_ready`, combinational.
  - `ip_tx_data` = `udp_tx_data`; `ip_tx_valid` = 1.
  - The byte counter increments on each transfer.
  - `ip_tx_last` is high when counter == L-1.
  - After the L-th transfer, `udp_tx_active` is 0 and state goes to DONE.
  - Exactly L payload bytes are consumed; `udp_tx_active` is never high outside PAYLOAD and DRAIN.
- **DRAIN (oversize L):**
  - Pulse `udp_tx_enable` for 1 cycle.
  - Then hold `udp_tx_active` = 1 for exactly L cycles.
  - Discard the data: `ip_tx_valid` = 0 and `ip_tx_request` = 0.
  - Increment `drop_count` (saturating), then go to DONE.
- **DONE:**
  - Increment `packet_count` (wrapping), except for drops.
  - Wait for `udp_tx_request` = 0, then go to IDLE. A new request held high continuously is never double-serviced.
- **Counter width:** the byte counter is 16 bits and compares against the latched L, never the live `udp_tx_length`.
- **Dropped request:** `udp_tx_request` falling before GRANT returns to IDLE with no grant and no IP request kept.
- **Backpressure:** `ip_tx_ready` low in HEADER or PAYLOAD freezes the byte index; `ip_tx_data` is held in HEADER.

Optional Feature:
- **With `UDP_TX_STATS_EN`:**
  - `packet_count` increments on each completed datagram, wrapping at 2^32.
  - `drop_count` increments on each DRAIN, saturating at 16'hFFFF.
  - Both clear on reset.
- **Without it:** both outputs are tied to 0 and no counter logic exists.

Test Plan:
- L=60, `port_ID`=0, `dest_port`=1024, ready always 1 → header bytes 04 00 04 00 00 44 00 00; then 60 payload bytes identical to the sender bytes; `ip_tx_last` on byte 68; `udp_tx_enable` high for 1 cycle.
- L=1028, `port_ID`=3, `ip_tx_ready` toggled 1/0 every cycle → source port 0x0403, length 0x040C; no byte lost or duplicated; `udp_tx_active` mirrors ready; 1036 transfers total.
- L=0 → only 8 header bytes, length field 0x0008, `ip_tx_last` on byte 8; `udp_tx_active` never asserted.
- L=1500 (> MAX_PAYLOAD) → no `ip_tx_request`; `udp_tx_active` high exactly 1500 cycles; `drop_count` 0→1; `packet_count` unchanged.
- `reset` asserted during PAYLOAD byte 20 → next edge: all outputs 0, `busy`=0; a fresh L=60 request afterwards completes normally.
- `udp_tx_request` held high across DONE for 5 cycles → no second grant until request drops and rises again; `packet_count` = 1.
